ifetch_bank_mux: RTL and testbench

- Parametrised instruction-fetch router between the core's fetch stage and N_BANK synchronous-read instruction memories (ROM, RAM, and future banks).
- Decodes each fetch address against per-bank base addresses and rebases it to a bank-local word address.
- Adds a valid/ready handshake, a one-entry skid buffer for back-pressure, flush on redirect, and fault reporting for misaligned and unmapped fetches.

---
 rtl/ifetch_bank_mux_if.sv | 36 +++
 rtl/ifetch_bank_mux.sv | 146 ++++++++++++++
 tb/tb_ifetch_bank_mux.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_bank_mux_if.sv
//------------------------------------------------------------------------------
// ifetch_bank_mux_if : fetch request/response and bank-side bus bundle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ifetch_bank_mux_if #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 14,
  parameter int N_BANK   = 2
);
  logic                            req_valid;
  logic                            req_ready;
  logic [ADDR_LEN-1:0]             req_addr;
  logic                            flush;
  logic                            rsp_valid;
  logic                            rsp_ready;
  logic [XLEN-1:0]                 rsp_data;
  logic [1:0]                      rsp_fault;
  logic [N_BANK-1:0]               bank_en;
  logic [N_BANK*(ADDR_LEN-2)-1:0]  bank_addr;
  logic [N_BANK*XLEN-1:0]          bank_data;

  // The master side is the fetch stage together with the memory banks.
  modport master (
    output req_valid, req_addr, flush, rsp_ready, bank_data,
    input  req_ready, rsp_valid, rsp_data, rsp_fault, bank_en, bank_addr
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready, bank_data,
    output req_ready, rsp_valid, rsp_data, rsp_fault, bank_en, bank_addr
  );
endinterface

`default_nettype wire

// File: rtl/ifetch_bank_mux.sv
//------------------------------------------------------------------------------
// ifetch_bank_mux : routes fetches to N_BANK sync-read memories with skid buffer,
//                   flush and fault reporting. Optional IFETCH_PERF_CNT_EN counters.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef RAM_BASE_ADDR
`define RAM_BASE_ADDR 14'h2000
`endif

module ifetch_bank_mux #(
  parameter int                         XLEN      = 32,
  parameter int                         ADDR_LEN  = 14,
  parameter int                         N_BANK    = 2,
  parameter logic [N_BANK*ADDR_LEN-1:0] BANK_BASE = {`RAM_BASE_ADDR, 14'h0000}
) (
  input wire               clk,
  input wire               rstb,
  ifetch_bank_mux_if.slave bus
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_stall_cnt
`endif
);

  localparam int c_IDX_W = (N_BANK > 1) ? $clog2(N_BANK) : 1;
  localparam int c_WA_W  = ADDR_LEN - 2;

  localparam logic [1:0] c_FLT_OK    = 2'b00;
  localparam logic [1:0] c_FLT_ALIGN = 2'b01;
  localparam logic [1:0] c_FLT_UNMAP = 2'b10;

  logic               r_p1_valid;
  logic [c_IDX_W-1:0] r_p1_bank;
  logic [1:0]         r_p1_fault;
  logic               r_hb_valid;
  logic [XLEN-1:0]    r_hb_data;
  logic [1:0]         r_hb_fault;

  logic [c_IDX_W-1:0] w_hit_idx;
  logic               w_mapped;
  logic [1:0]         w_fault;
  logic               w_req_ready;
  logic               w_accept;
  logic               w_issue;
  logic [XLEN-1:0]    w_p1_data;
  logic               w_rsp_valid;

  // Bases ascend, so the last base not above the address names the bank.
  always_comb begin
    w_hit_idx = '0;
    w_mapped  = 1'b0;
    for (int i = 0; i < N_BANK; i++) begin
      if (bus.req_addr >= BANK_BASE[i*ADDR_LEN +: ADDR_LEN]) begin
        w_hit_idx = c_IDX_W'(i);
        w_mapped  = 1'b1;
      end
    end
  end

  always_comb begin
    w_fault = c_FLT_OK;
    if (bus.req_addr[1:0] != 2'b00) begin
      w_fault = c_FLT_ALIGN;
    end else if (!w_mapped) begin
      w_fault = c_FLT_UNMAP;
    end
  end

  assign w_req_ready = !r_hb_valid;
  assign w_accept    = bus.req_valid && w_req_ready;
  // Gated by rstb so no bank read is issued while reset is held.
  assign w_issue     = w_accept && (w_fault == c_FLT_OK) && rstb;

  for (genvar g = 0; g < N_BANK; g++) begin : g_bank
    // Bases are word aligned, so subtracting the word fields equals the byte subtraction.
    assign bus.bank_addr[g*c_WA_W +: c_WA_W] =
      bus.req_addr[ADDR_LEN-1:2] - BANK_BASE[g*ADDR_LEN+2 +: c_WA_W];
    assign bus.bank_en[g] = w_issue && (w_hit_idx == c_IDX_W'(g));
  end

  assign w_p1_data = (r_p1_fault != c_FLT_OK) ? '0 : bus.bank_data[r_p1_bank*XLEN +: XLEN];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_p1_valid <= 1'b0;
      r_p1_bank  <= '0;
      r_p1_fault <= c_FLT_OK;
      r_hb_valid <= 1'b0;
      r_hb_data  <= '0;
      r_hb_fault <= c_FLT_OK;
    end else begin
      if (w_accept) begin
        r_p1_bank  <= w_hit_idx;
        r_p1_fault <= w_fault;
      end
      if (bus.flush) begin
        r_hb_valid <= 1'b0;
        r_p1_valid <= w_accept;
      end else if (r_hb_valid) begin
        // No acceptance is possible here, so p1 and its bank output stay frozen.
        r_hb_valid <= !bus.rsp_ready;
      end else begin
        r_hb_valid <= r_p1_valid && !bus.rsp_ready;
        r_p1_valid <= w_accept;
        if (r_p1_valid && !bus.rsp_ready) begin
          r_hb_data  <= w_p1_data;
          r_hb_fault <= r_p1_fault;
        end
      end
    end
  end

  assign w_rsp_valid   = (r_hb_valid || r_p1_valid) && !bus.flush;
  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = r_hb_valid ? r_hb_data  : (r_p1_valid ? w_p1_data  : '0);
  assign bus.rsp_fault = r_hb_valid ? r_hb_fault : (r_p1_valid ? r_p1_fault : c_FLT_OK);

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept && (w_fault == c_FLT_OK)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_rsp_valid && !bus.rsp_ready) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch_bank_mux.sv
//------------------------------------------------------------------------------
// tb_ifetch_bank_mux : scenario and randomized checks against a queue-based model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ifetch_bank_mux;
  localparam logic [13:0] BASE [2] = '{14'h0000, 14'h2000};

  typedef struct {
    logic [31:0] data;
    logic [1:0]  fault;
  } rsp_t;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  ifetch_bank_mux_if #(.XLEN(32), .ADDR_LEN(14), .N_BANK(2)) bus ();
  ifetch_bank_mux_if #(.XLEN(32), .ADDR_LEN(14), .N_BANK(2)) bus2 ();

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf2_fetch, perf2_stall;
  ifetch_bank_mux #(.XLEN(32), .ADDR_LEN(14), .N_BANK(2), .BANK_BASE({14'h2000, 14'h0000}))
    dut (.clk(clk), .rstb(rstb), .bus(bus),
         .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt));
  ifetch_bank_mux #(.XLEN(32), .ADDR_LEN(14), .N_BANK(2), .BANK_BASE({14'h2000, 14'h0100}))
    dut2 (.clk(clk), .rstb(rstb), .bus(bus2),
          .perf_fetch_cnt(perf2_fetch), .perf_stall_cnt(perf2_stall));
`else
  ifetch_bank_mux #(.XLEN(32), .ADDR_LEN(14), .N_BANK(2), .BANK_BASE({14'h2000, 14'h0000}))
    dut (.clk(clk), .rstb(rstb), .bus(bus));
  ifetch_bank_mux #(.XLEN(32), .ADDR_LEN(14), .N_BANK(2), .BANK_BASE({14'h2000, 14'h0100}))
    dut2 (.clk(clk), .rstb(rstb), .bus(bus2));
`endif

  // Memory banks: registered read, output held while not enabled.
  logic [31:0] mem [2][4096];
  logic [31:0] bank_q [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bus.bank_en[i]) bank_q[i] <= mem[i][bus.bank_addr[i*12 +: 12]];
    end
  end
  assign bus.bank_data  = {bank_q[1], bank_q[0]};
  assign bus2.bank_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  rsp_t q[$];
  bit   m_hb = 1'b0;

  // Per-cycle observations and model expectations
  logic        o_rdy, o_vld;
  logic [31:0] o_data;
  logic [1:0]  o_fault;
  logic [1:0]  o_en;
  logic [23:0] o_baddr;
  logic        e_rdy, e_vld, e_acc;
  logic [31:0] e_data;
  logic [1:0]  e_fault;
  logic [1:0]  e_en;

  function automatic int bank_of(logic [13:0] a);
    int b = 0;
    for (int i = 0; i < 2; i++) if (a >= BASE[i]) b = i;
    return b;
  endfunction

  function automatic logic [1:0] fault_of(logic [13:0] a);
    if (a[1:0] != 2'b00) return 2'b01;
    if (a < BASE[0]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [11:0] word_of(logic [13:0] a);
    logic [13:0] d;
    d = a - BASE[bank_of(a)];
    return d[13:2];
  endfunction

  function automatic logic [11:0] baddr_field(logic [23:0] v, int b);
    return v[b*12 +: 12];
  endfunction

  // Drives one cycle, records outputs and model expectations, then advances the model.
  task automatic cycle(input bit v, input logic [13:0] a, input bit fl, input bit rr);
    bit nh;
    rsp_t r;
    @(negedge clk);
    bus.req_valid = v; bus.req_addr = a; bus.flush = fl; bus.rsp_ready = rr;
    #1;
    o_rdy = bus.req_ready; o_vld = bus.rsp_valid; o_data = bus.rsp_data;
    o_fault = bus.rsp_fault; o_en = bus.bank_en; o_baddr = bus.bank_addr;
    e_rdy   = !m_hb;
    e_vld   = (q.size() > 0) && !fl;
    e_data  = (q.size() > 0) ? q[0].data  : 32'h0;
    e_fault = (q.size() > 0) ? q[0].fault : 2'b00;
    e_acc   = v && e_rdy;
    e_en    = (e_acc && fault_of(a) == 2'b00) ? 2'(1 << bank_of(a)) : 2'b00;
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_hb = 1'b0;
    end else begin
      nh = m_hb ? !rr : ((q.size() > 0) && !rr);
      if (e_vld && rr) void'(q.pop_front());
      m_hb = nh;
    end
    if (e_acc) begin
      r.fault = fault_of(a);
      r.data  = (r.fault != 2'b00) ? 32'h0 : mem[bank_of(a)][word_of(a)];
      q.push_back(r);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b1; bus.req_addr = 14'h0000; bus.flush = 1'b0; bus.rsp_ready = 1'b1;
    bus2.req_valid = 1'b0; bus2.req_addr = 14'h0; bus2.flush = 1'b0; bus2.rsp_ready = 1'b1;
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 || bus.rsp_fault !== 2'b00 ||
        bus.bank_en !== 2'b00 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_during: vld=%b data=%h flt=%b en=%b rdy=%b, need 0/0/0/00/1",
               bus.rsp_valid, bus.rsp_data, bus.rsp_fault, bus.bank_en, bus.req_ready);
    end
    bus.req_valid = 1'b0;
    rstb = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_after: vld=%b data=%h rdy=%b, need 0/0/1", bus.rsp_valid, bus.rsp_data, bus.req_ready);
    end
  endtask

  task automatic test_streaming();
    logic [13:0] addrs [4] = '{14'h0000, 14'h0004, 14'h2000, 14'h2008};
    logic [1:0]  ens   [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
    logic [11:0] was   [4] = '{12'd0, 12'd1, 12'd0, 12'd2};
    for (int c = 0; c < 5; c++) begin
      if (c < 4) cycle(1'b1, addrs[c], 1'b0, 1'b1);
      else cycle(1'b0, 14'h0, 1'b0, 1'b1);
      if (c < 4) begin
        n_checks++;
        if (o_en !== ens[c] || baddr_field(o_baddr, (ens[c] == 2'b10) ? 1 : 0) !== was[c]) begin
          n_fail++;
          $display("FAIL stream_bank c%0d: en=%b waddr=%h, need en=%b waddr=%h", c, o_en,
                   baddr_field(o_baddr, (ens[c] == 2'b10) ? 1 : 0), ens[c], was[c]);
        end
      end
      n_checks++;
      if (o_vld !== (c > 0) || (c > 0 && (o_data !== e_data || o_fault !== 2'b00))) begin
        n_fail++;
        $display("FAIL stream_rsp c%0d: vld=%b data=%h flt=%b, need vld=%b data=%h flt=00",
                 c, o_vld, o_data, o_fault, (c > 0), e_data);
      end
    end
  endtask

  task automatic test_backpressure();
    logic        rr  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int          seen = 0;
    logic [31:0] want [2];
    want[0] = mem[0][4];
    want[1] = mem[1][1];
    for (int c = 0; c < 7; c++) begin
      cycle(c < 2, (c == 0) ? 14'h0010 : 14'h2004, 1'b0, rr[c]);
      if (c == 2 || c == 3) begin
        n_checks++;
        if (o_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_ready c%0d: rdy=%b, need 0", c, o_rdy);
        end
      end
      if (o_vld && rr[c]) begin
        n_checks++;
        if (seen > 1 || o_data !== want[seen] || o_fault !== 2'b00) begin
          n_fail++;
          $display("FAIL bp_order c%0d idx%0d: data=%h flt=%b, need data=%h flt=00",
                   c, seen, o_data, o_fault, (seen < 2) ? want[seen] : 32'h0);
        end
        seen++;
      end
    end
    n_checks++;
    if (seen != 2) begin
      n_fail++;
      $display("FAIL bp_count: got %0d responses, need 2", seen);
    end
  endtask

  task automatic test_faults();
    cycle(1'b1, 14'h2002, 1'b0, 1'b1);
    n_checks++;
    if (o_en !== 2'b00) begin
      n_fail++;
      $display("FAIL align_en: en=%b, need 00", o_en);
    end
    cycle(1'b1, 14'h3FFC, 1'b0, 1'b1);
    n_checks++;
    if (o_vld !== 1'b1 || o_fault !== 2'b01 || o_data !== 32'h0) begin
      n_fail++;
      $display("FAIL align_rsp: vld=%b flt=%b data=%h, need 1/01/0", o_vld, o_fault, o_data);
    end
    n_checks++;
    if (o_en !== 2'b10 || baddr_field(o_baddr, 1) !== 12'h7FF) begin
      n_fail++;
      $display("FAIL top_word: en=%b waddr=%h, need 10/7ff", o_en, baddr_field(o_baddr, 1));
    end
    cycle(1'b0, 14'h0, 1'b0, 1'b1);
    n_checks++;
    if (o_vld !== 1'b1 || o_fault !== 2'b00 || o_data !== mem[1][12'h7FF]) begin
      n_fail++;
      $display("FAIL top_rsp: vld=%b flt=%b data=%h, need 1/00/%h", o_vld, o_fault, o_data, mem[1][12'h7FF]);
    end
    // Second instance with bank 0 based at 0x0100
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_addr = 14'h0040;
    #1;
    n_checks++;
    if (bus2.bank_en !== 2'b00 || bus2.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL unmap_en: en=%b rdy=%b, need 00/1", bus2.bank_en, bus2.req_ready);
    end
    @(negedge clk);
    bus2.req_addr = 14'h0100;
    #1;
    n_checks++;
    if (bus2.rsp_valid !== 1'b1 || bus2.rsp_fault !== 2'b10 || bus2.rsp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL unmap_rsp: vld=%b flt=%b data=%h, need 1/10/0", bus2.rsp_valid, bus2.rsp_fault, bus2.rsp_data);
    end
    n_checks++;
    if (bus2.bank_en !== 2'b01 || bus2.bank_addr[11:0] !== 12'h000) begin
      n_fail++;
      $display("FAIL base_edge: en=%b waddr=%h, need 01/000", bus2.bank_en, bus2.bank_addr[11:0]);
    end
    @(negedge clk);
    bus2.req_valid = 1'b0;
    #1;
    n_checks++;
    if (bus2.rsp_valid !== 1'b1 || bus2.rsp_fault !== 2'b00) begin
      n_fail++;
      $display("FAIL base_rsp: vld=%b flt=%b, need 1/00", bus2.rsp_valid, bus2.rsp_fault);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    cycle(1'b1, 14'h0020, 1'b0, 1'b1);
    cycle(1'b1, 14'h2024, 1'b0, 1'b0);
    cycle(1'b1, 14'h2010, 1'b1, 1'b0);
    n_checks++;
    if (o_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_vld: vld=%b, need 0", o_vld);
    end
    for (int c = 0; c < 5; c++) begin
      cycle(!e_acc && c == 0, 14'h2010, 1'b0, 1'b1);
      if (o_vld) begin
        n_checks++;
        if (seen > 0 || o_data !== mem[1][4] || o_fault !== 2'b00) begin
          n_fail++;
          $display("FAIL flush_rsp idx%0d: data=%h flt=%b, need one response %h", seen, o_data, o_fault, mem[1][4]);
        end
        seen++;
      end
    end
    n_checks++;
    if (seen != 1) begin
      n_fail++;
      $display("FAIL flush_count: got %0d responses, need 1", seen);
    end
  endtask

  task automatic test_reset_midop();
    cycle(1'b1, 14'h0030, 1'b0, 1'b1);
    cycle(1'b1, 14'h0034, 1'b0, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 14'h0038; bus.rsp_ready = 1'b0;
    #1;
    rstb = 1'b0;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.bank_en !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_async: vld=%b en=%b, need 0/00", bus.rsp_valid, bus.bank_en);
    end
    @(posedge clk); #2;
    rstb = 1'b1;
    q.delete();
    m_hb = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready: rdy=%b, need 1", bus.req_ready);
    end
    cycle(1'b1, 14'h2008, 1'b0, 1'b1);
    cycle(1'b0, 14'h0, 1'b0, 1'b1);
    n_checks++;
    if (o_vld !== 1'b1 || o_data !== mem[1][2] || o_fault !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_fetch: vld=%b data=%h flt=%b, need 1/%h/00", o_vld, o_data, o_fault, mem[1][2]);
    end
  endtask

  task automatic test_random();
    logic [13:0] a;
    bit v, fl, rr;
    for (int c = 0; c < 400; c++) begin
      a  = 14'($urandom);
      if ($urandom_range(0, 9) != 0) a[1:0] = 2'b00;
      v  = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 19) == 0);
      rr = ($urandom_range(0, 9) < 7);
      cycle(v, a, fl, rr);
      n_checks++;
      if (o_rdy !== e_rdy || o_en !== e_en) begin
        n_fail++;
        $display("FAIL rnd_ctl c%0d: rdy=%b en=%b, need rdy=%b en=%b", c, o_rdy, o_en, e_rdy, e_en);
      end
      if (e_en != 2'b00) begin
        n_checks++;
        if (baddr_field(o_baddr, bank_of(a)) !== word_of(a)) begin
          n_fail++;
          $display("FAIL rnd_waddr c%0d a=%h: waddr=%h, need %h", c, a, baddr_field(o_baddr, bank_of(a)), word_of(a));
        end
      end
      n_checks++;
      if (o_vld !== e_vld || (e_vld && (o_data !== e_data || o_fault !== e_fault))) begin
        n_fail++;
        $display("FAIL rnd_rsp c%0d: vld=%b data=%h flt=%b, need vld=%b data=%h flt=%b",
                 c, o_vld, o_data, o_fault, e_vld, e_data, e_fault);
      end
    end
    for (int c = 0; c < 3; c++) cycle(1'b0, 14'h0, 1'b0, 1'b1);
  endtask

`ifdef IFETCH_PERF_CNT_EN
  task automatic test_perf();
    logic [31:0] f0, s0;
    logic [13:0] addrs [5] = '{14'h0040, 14'h0044, 14'h2006, 14'h2040, 14'h0048};
    @(negedge clk);
    f0 = perf_fetch_cnt;
    s0 = perf_stall_cnt;
    for (int c = 0; c < 5; c++) cycle(1'b1, addrs[c], 1'b0, 1'b1);
    cycle(1'b0, 14'h0, 1'b0, 1'b0);
    cycle(1'b0, 14'h0, 1'b0, 1'b0);
    cycle(1'b0, 14'h0, 1'b0, 1'b1);
    cycle(1'b0, 14'h0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (perf_fetch_cnt - f0 !== 32'd4 || perf_stall_cnt - s0 !== 32'd2) begin
      n_fail++;
      $display("FAIL perf_cnt: fetch+%0d stall+%0d, need fetch+4 stall+2",
               perf_fetch_cnt - f0, perf_stall_cnt - s0);
    end
  endtask
`endif

  initial begin
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w < 4096; w++) mem[b][w] = $urandom;
    end
    test_reset();
    test_streaming();
    test_backpressure();
    test_faults();
    test_flush();
    test_reset_midop();
    test_random();
`ifdef IFETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
